// File: rtl/ccl_engine_param.sv
// ccl_engine_param: two-pass connected-component labeller, 1-bpp ROM image in, SRAM label map out.
// Build macro CCL_COMPACT_LABELS_EN renumbers final labels 1..label_count; otherwise roots keep their label.
module ccl_engine_param #(
    parameter int IMG_W   = 32,
    parameter int IMG_H   = 32,
    parameter int ROM_DW  = 8,
    parameter int LABEL_W = 8,
    parameter int CONN8   = 1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    output logic [$clog2(IMG_W*IMG_H/ROM_DW)-1:0]  rom_a,
    input  logic [ROM_DW-1:0]                      rom_q,
    output logic [$clog2(IMG_W*IMG_H)-1:0]         sram_a,
    output logic [LABEL_W-1:0]                     sram_d,
    output logic                                   sram_wen,
    input  logic [LABEL_W-1:0]                     sram_q,
    output logic                                   busy,
    output logic                                   finish,
    output logic                                   overflow,
    output logic [LABEL_W-1:0]                     label_count
);

    localparam int N_PIX   = IMG_W * IMG_H;
    localparam int N_WORDS = N_PIX / ROM_DW;
    localparam int AW      = $clog2(N_WORDS);
    localparam int PW      = $clog2(N_PIX);
    localparam int CW      = $clog2(IMG_W);
    localparam int NLAB    = 1 << LABEL_W;

    localparam logic [AW-1:0]      ROM_LAST = AW'(N_WORDS - 1);
    localparam logic [AW:0]        LOAD_END = (AW+1)'(N_WORDS);
    localparam logic [PW-1:0]      PIX_LAST = PW'(N_PIX - 1);
    localparam logic [CW-1:0]      COL_LAST = CW'(IMG_W - 1);
    localparam logic [LABEL_W:0]   NL_FULL  = (LABEL_W+1)'(NLAB);
    localparam logic [LABEL_W:0]   NL_ONE   = (LABEL_W+1)'(1);
    localparam logic [LABEL_W-1:0] LAB_MAX  = {LABEL_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SCAN, S_MERGE, S_RESOLVE, S_RELABEL, S_DONE
    } state_t;

    state_t state_r, state_s;

    logic [N_PIX-1:0]   img_r;
    logic [LABEL_W-1:0] lb_r     [IMG_W];
    logic [LABEL_W-1:0] parent_r [NLAB];
    logic [LABEL_W-1:0] final_r  [NLAB];
    logic [LABEL_W-1:0] q_r      [4];

    logic [AW:0]        load_cnt_r;
    logic [PW-1:0]      pix_r;
    logic [CW-1:0]      col_r;
    logic               first_row_r, scan_done_r, phase_r;
    logic [LABEL_W-1:0] w_r, nw_r, m_r, a_r, b_r, res_i_r, rc_r, sram_d_r;
    logic [LABEL_W:0]   next_label_r;
    logic [3:0]         pend_r;

    logic               start_acc_s, fg_s, new_s, ovf_s, roots_s, res_done_s, is_root_s;
    logic [LABEL_W-1:0] nb_s [4];
    logic [LABEL_W-1:0] m_s, lab_s, par_a_s, par_b_s, res_p_s, res_final_s, rc_next_s, relabel_d_s;
    logic [CW-1:0]      ne_idx_s;
    logic [3:0]         pend_s;
    logic [1:0]         sel_s, sel_r_s;
    logic [PW-1:0]      load_base_s;
    logic [ROM_DW-1:0]  rom_rev_s;

    function automatic logic [LABEL_W-1:0] min_nz(input logic [LABEL_W-1:0] x, input logic [LABEL_W-1:0] y);
        if (x == '0)      return y;
        else if (y == '0) return x;
        else if (x < y)   return x;
        else              return y;
    endfunction

    function automatic logic [1:0] first_set(input logic [3:0] v);
        if (v[0])      return 2'd0;
        else if (v[1]) return 2'd1;
        else if (v[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    // Neighbour gathering and provisional label choice for the current scan pixel.
    always_comb begin
        start_acc_s = start && (state_r == S_IDLE || state_r == S_DONE);
        fg_s        = img_r[pix_r];
        ne_idx_s    = (col_r == COL_LAST) ? col_r : col_r + 1'b1;
        nb_s[0]     = (col_r != '0) ? w_r : '0;
        nb_s[1]     = (CONN8 != 0 && !first_row_r && col_r != '0) ? nw_r : '0;
        nb_s[2]     = first_row_r ? '0 : lb_r[col_r];
        nb_s[3]     = (CONN8 != 0 && !first_row_r && col_r != COL_LAST) ? lb_r[ne_idx_s] : '0;
        m_s         = min_nz(min_nz(nb_s[0], nb_s[1]), min_nz(nb_s[2], nb_s[3]));
        new_s       = fg_s && (m_s == '0);
        ovf_s       = new_s && (next_label_r == NL_FULL);
        if (!fg_s)             lab_s = '0;
        else if (m_s != '0)    lab_s = m_s;
        else if (ovf_s)        lab_s = LAB_MAX;
        else                   lab_s = next_label_r[LABEL_W-1:0];
        for (int k = 0; k < 4; k++) begin
            pend_s[k] = fg_s && (nb_s[k] != '0) && (nb_s[k] != m_s);
        end
        sel_s       = first_set(pend_s);
        sel_r_s     = first_set(pend_r);
        load_base_s = PW'(load_cnt_r - 1'b1) * PW'(ROM_DW);
        for (int j = 0; j < ROM_DW; j++) begin
            rom_rev_s[j] = rom_q[ROM_DW-1-j];
        end
    end

    // Union-find walk, resolve step and relabel lookup.
    always_comb begin
        par_a_s    = parent_r[a_r];
        par_b_s    = parent_r[b_r];
        roots_s    = (par_a_s == a_r) && (par_b_s == b_r);
        res_p_s    = parent_r[res_i_r];
        res_done_s = (next_label_r == NL_ONE) || ({1'b0, res_i_r} == next_label_r - 1'b1);
        is_root_s  = (next_label_r != NL_ONE) && (res_p_s == res_i_r);
        rc_next_s  = (is_root_s && rc_r != LAB_MAX) ? rc_r + 1'b1 : rc_r;
        if (res_p_s != res_i_r) begin
            res_final_s = final_r[res_p_s];
        end else begin
`ifdef CCL_COMPACT_LABELS_EN
            res_final_s = rc_r + 1'b1;
`else
            res_final_s = res_i_r;
`endif
        end
        relabel_d_s = (sram_q == '0) ? '0 : final_r[sram_q];
        if (state_r == S_RELABEL && phase_r) sram_d = relabel_d_s;
        else                                 sram_d = sram_d_r;
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE, S_DONE: if (start_acc_s) state_s = S_LOAD; else state_s = state_r;
            S_LOAD:         if (load_cnt_r == LOAD_END) state_s = S_SCAN; else state_s = state_r;
            S_SCAN: begin
                if (pend_s != 4'b0000)       state_s = S_MERGE;
                else if (pix_r == PIX_LAST)  state_s = S_RESOLVE;
                else                         state_s = state_r;
            end
            S_MERGE: begin
                if (roots_s && pend_r == 4'b0000) state_s = scan_done_r ? S_RESOLVE : S_SCAN;
                else                              state_s = state_r;
            end
            S_RESOLVE:  if (res_done_s) state_s = S_RELABEL; else state_s = state_r;
            S_RELABEL:  if (phase_r && pix_r == PIX_LAST) state_s = S_DONE; else state_s = state_r;
            default:    state_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_r <= S_IDLE;
        else       state_r <= state_s;
    end

    // Control counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            rom_a <= '0; sram_a <= '0; sram_d_r <= '0; sram_wen <= 1'b1;
            busy <= 1'b0; finish <= 1'b0; overflow <= 1'b0; label_count <= '0;
            load_cnt_r <= '0; pix_r <= '0; col_r <= '0; first_row_r <= 1'b1;
            scan_done_r <= 1'b0; phase_r <= 1'b0; w_r <= '0; nw_r <= '0; m_r <= '0;
            a_r <= '0; b_r <= '0; res_i_r <= '0; rc_r <= '0; pend_r <= 4'b0000;
            next_label_r <= NL_ONE;
            for (int k = 0; k < 4; k++) q_r[k] <= '0;
        end else begin
            sram_wen <= 1'b1;
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (start_acc_s) begin
                        busy <= 1'b1; finish <= 1'b0; overflow <= 1'b0; label_count <= '0;
                        next_label_r <= NL_ONE; rom_a <= '0; load_cnt_r <= '0;
                    end
                end
                S_LOAD: begin
                    load_cnt_r <= load_cnt_r + 1'b1;
                    if (rom_a != ROM_LAST) rom_a <= rom_a + 1'b1;
                    if (load_cnt_r == LOAD_END) begin
                        pix_r <= '0; col_r <= '0; first_row_r <= 1'b1; scan_done_r <= 1'b0;
                        w_r <= '0; nw_r <= '0;
                    end
                end
                S_SCAN: begin
                    sram_a <= pix_r; sram_d_r <= lab_s; sram_wen <= 1'b0;
                    w_r <= lab_s; nw_r <= nb_s[2]; m_r <= m_s;
                    for (int k = 0; k < 4; k++) q_r[k] <= nb_s[k];
                    if (new_s && !ovf_s) next_label_r <= next_label_r + 1'b1;
                    if (ovf_s) overflow <= 1'b1;
                    scan_done_r <= (pix_r == PIX_LAST);
                    if (pix_r != PIX_LAST) begin
                        pix_r <= pix_r + 1'b1;
                        if (col_r == COL_LAST) begin
                            col_r <= '0; first_row_r <= 1'b0;
                        end else begin
                            col_r <= col_r + 1'b1;
                        end
                    end
                    if (pend_s != 4'b0000) begin
                        a_r <= nb_s[sel_s]; b_r <= m_s;
                        pend_r <= pend_s & ~(4'b0001 << sel_s);
                    end
                end
                S_MERGE: begin
                    if (roots_s) begin
                        if (pend_r != 4'b0000) begin
                            a_r <= q_r[sel_r_s]; b_r <= m_r;
                            pend_r <= pend_r & ~(4'b0001 << sel_r_s);
                        end
                    end else begin
                        a_r <= par_a_s; b_r <= par_b_s;
                    end
                end
                S_RESOLVE: begin
                    res_i_r <= res_i_r + 1'b1;
                    rc_r <= rc_next_s;
                    if (res_done_s) begin
                        label_count <= rc_next_s; pix_r <= '0; sram_a <= '0; phase_r <= 1'b0;
                    end
                end
                S_RELABEL: begin
                    if (!phase_r) begin
                        phase_r <= 1'b1; sram_wen <= 1'b0;
                    end else begin
                        phase_r <= 1'b0;
                        if (pix_r == PIX_LAST) begin
                            busy <= 1'b0; finish <= 1'b1;
                        end else begin
                            pix_r <= pix_r + 1'b1; sram_a <= pix_r + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
            if (state_s == S_RESOLVE && state_r != S_RESOLVE) begin
                res_i_r <= LABEL_W'(1); rc_r <= '0;
            end
        end
    end

    // Image, line buffer, parent and final-label tables (contents are don't-care until a job fills them).
    always_ff @(posedge clk) begin
        case (state_r)
            S_IDLE, S_DONE: begin
                if (start_acc_s) begin
                    for (int i = 0; i < NLAB; i++) parent_r[i] <= LABEL_W'(i);
                end
            end
            S_LOAD: begin
                if (load_cnt_r != '0) img_r[load_base_s +: ROM_DW] <= rom_rev_s;
            end
            S_SCAN:  lb_r[col_r] <= lab_s;
            S_MERGE: begin
                if (roots_s && a_r != b_r) begin
                    if (a_r > b_r) parent_r[a_r] <= b_r;
                    else           parent_r[b_r] <= a_r;
                end
            end
            S_RESOLVE: begin
                if (next_label_r != NL_ONE) final_r[res_i_r] <= res_final_s;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ccl_engine_param.sv
// Directed bench for ccl_engine_param: an 8-connected and a 4-connected instance label the same images.
module tb_ccl_engine_param;

    localparam int W  = 32;
    localparam int NP = 1024;
    localparam int NW = 128;

    logic clk = 1'b0;
    logic reset, start;
    always #5 clk = ~clk;

    logic [7:0] rom_mem [NW];
    logic [6:0] rom_a8, rom_a4;
    logic [7:0] rom_q8, rom_q4;
    logic [9:0] sram_a8, sram_a4;
    logic [7:0] sram_d8, sram_d4, sram_q8, sram_q4, label_count8, label_count4;
    logic       sram_wen8, sram_wen4, busy8, busy4, finish8, finish4, overflow8, overflow4;
    logic [7:0] mem8 [NP];
    logic [7:0] mem4 [NP];
    logic       img  [NP];
    int         exp8 [NP];
    int         exp4 [NP];
    int         n_checks = 0;
    int         n_fail   = 0;

    ccl_engine_param #(.CONN8(1)) u_dut8 (
        .clk(clk), .reset(reset), .start(start), .rom_a(rom_a8), .rom_q(rom_q8),
        .sram_a(sram_a8), .sram_d(sram_d8), .sram_wen(sram_wen8), .sram_q(sram_q8),
        .busy(busy8), .finish(finish8), .overflow(overflow8), .label_count(label_count8));

    ccl_engine_param #(.CONN8(0)) u_dut4 (
        .clk(clk), .reset(reset), .start(start), .rom_a(rom_a4), .rom_q(rom_q4),
        .sram_a(sram_a4), .sram_d(sram_d4), .sram_wen(sram_wen4), .sram_q(sram_q4),
        .busy(busy4), .finish(finish4), .overflow(overflow4), .label_count(label_count4));

    // Synchronous ROM and SRAM models, one-cycle read latency.
    always @(posedge clk) begin
        rom_q8 <= rom_mem[rom_a8];
        rom_q4 <= rom_mem[rom_a4];
        if (!sram_wen8) mem8[sram_a8] <= sram_d8;
        if (!sram_wen4) mem4[sram_a4] <= sram_d4;
        sram_q8 <= mem8[sram_a8];
        sram_q4 <= mem4[sram_a4];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic clear_img();
        for (int i = 0; i < NP; i++) begin
            img[i] = 1'b0; exp8[i] = 0; exp4[i] = 0;
        end
    endtask

    task automatic set_px(input int r, input int c, input int l8, input int l4);
        img[r*W+c] = 1'b1; exp8[r*W+c] = l8; exp4[r*W+c] = l4;
    endtask

    task automatic pack_rom();
        for (int w = 0; w < NW; w++)
            for (int j = 0; j < 8; j++)
                rom_mem[w][7-j] = img[w*8+j];
    endtask

    task automatic run_job(input string tag);
        int cyc;
        pack_rom();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk({tag, " busy8 after start"}, busy8, 1);
        chk({tag, " finish8 cleared"}, finish8, 0);
        cyc = 0;
        while (!(finish8 === 1'b1 && finish4 === 1'b1) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, " finish8"}, finish8, 1);
        chk({tag, " finish4"}, finish4, 1);
        chk({tag, " busy8 done"}, busy8, 0);
        chk({tag, " busy4 done"}, busy4, 0);
    endtask

    task automatic check_result(input string tag, input int lc8, input int lc4, input int ov8, input int ov4);
        int bad8, bad4;
        bad8 = 0; bad4 = 0;
        for (int i = 0; i < NP; i++) begin
            if (mem8[i] !== 8'(exp8[i])) bad8++;
            if (mem4[i] !== 8'(exp4[i])) bad4++;
        end
        chk({tag, " label_count8"}, label_count8, lc8);
        chk({tag, " label_count4"}, label_count4, lc4);
        chk({tag, " overflow8"}, overflow8, ov8);
        chk({tag, " overflow4"}, overflow4, ov4);
        chk({tag, " sram8 wrong words"}, bad8, 0);
        chk({tag, " sram4 wrong words"}, bad4, 0);
    endtask

    initial begin
        int k, la, lb, lc;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst busy", busy8, 0);
        chk("rst finish", finish8, 0);
        chk("rst overflow", overflow8, 0);
        chk("rst label_count", label_count8, 0);
        chk("rst sram_wen", sram_wen8, 1);
        chk("rst rom_a", rom_a8, 0);
        chk("rst sram_a", sram_a8, 0);
        chk("rst sram_d", sram_d8, 0);
        chk("rst sram_wen4", sram_wen4, 1);
        reset = 1'b0;
        @(negedge clk);

        // Empty image.
        clear_img();
        run_job("zero");
        check_result("zero", 0, 0, 0, 0);
        repeat (5) @(negedge clk);
        chk("zero finish held", finish8, 1);

        // All-ones image.
        clear_img();
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++) set_px(r, c, 1, 1);
        run_job("ones");
        check_result("ones", 1, 1, 0, 0);

        // U shape: two columns joined by a bottom bar.
        clear_img();
        for (int r = 0; r < 10; r++) begin
            set_px(r, 2, 1, 1);
            set_px(r, 9, 1, 1);
        end
        for (int c = 2; c <= 9; c++) set_px(10, c, 1, 1);
        run_job("ushape");
        check_result("ushape", 1, 1, 0, 0);

        // Diagonal pixels: one blob in 8-conn, three in 4-conn.
        clear_img();
        for (int d = 0; d < 3; d++) set_px(d, d, 1, d + 1);
        run_job("diag");
        check_result("diag", 1, 3, 0, 0);

        // 256 isolated pixels: label space runs out on the last one.
        clear_img();
        k = 0;
        for (int r = 0; r < 32; r += 2)
            for (int c = 0; c < 32; c += 2) begin
                k++;
                set_px(r, c, (k > 255) ? 255 : k, (k > 255) ? 255 : k);
            end
        run_job("grid");
        check_result("grid", 255, 255, 1, 1);

        // Three combs with provisional roots 1, 4, 7; reset lands mid-relabel, then rerun.
`ifdef CCL_COMPACT_LABELS_EN
        la = 1; lb = 2; lc = 3;
`else
        la = 1; lb = 4; lc = 7;
`endif
        clear_img();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c <= 4; c += 2) begin
                set_px(r, c, la, la);
                set_px(r, c + 8, lb, lb);
            end
        for (int c = 0; c <= 4; c++) begin
            set_px(3, c, la, la);
            set_px(3, c + 8, lb, lb);
        end
        for (int r = 0; r < 4; r++) set_px(r, 16, lc, lc);
        pack_rom();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (2000) @(negedge clk);
        chk("comb busy before reset", busy8, 1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("comb reset sram_wen8", sram_wen8, 1);
        chk("comb reset sram_wen4", sram_wen4, 1);
        chk("comb reset busy8", busy8, 0);
        chk("comb reset finish8", finish8, 0);
        reset = 1'b0;
        @(negedge clk);
        run_job("comb");
        check_result("comb", 3, 3, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
